// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake, iterative shifts and NZCV flags
// Optional shift-add multiplier (opcode 9) enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter int DATA_WIDTH   = 36,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic [ALU_OP_WIDTH-1:0] i_op,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_result,
    output logic [3:0]              o_flags,
    output logic                    o_err
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int CW          = SHAMT_WIDTH + 1;
    localparam int MSB         = DATA_WIDTH - 1;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA = ALU_OP_WIDTH'(8);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [ALU_OP_WIDTH-1:0] OP_MUL = ALU_OP_WIDTH'(9);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        MUL   = 2'd3,
`endif
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [3:0]              flags_q, flags_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic [CW-1:0]           shift_count;
    logic [DATA_WIDTH:0]     add_sum;
    logic [DATA_WIDTH:0]     sub_sum;
    logic                    add_v;
    logic                    sub_v;
    logic [DATA_WIDTH-1:0]   sh_val;
    logic                    sh_out;

`ifdef ALU_SEQ_MUL_EN
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
    logic [DATA_WIDTH:0]     mul_sum;
    logic                    mul_hi_nz;
`endif

    function automatic logic [1:0] nz(input logic [DATA_WIDTH-1:0] r);
        return {r[MSB], r == '0};
    endfunction

    assign accept  = i_valid && o_ready;
    assign o_ready = (state_q == IDLE) && !i_rst;
    assign o_valid = (state_q == DONE);
    assign o_result = result_q;
    assign o_flags  = flags_q;
    assign o_err    = err_q;

    // Amounts at or beyond the width saturate to exactly DATA_WIDTH single-bit steps.
    assign shift_count = ({1'b0, i_b[SHAMT_WIDTH-1:0]} >= CW'(DATA_WIDTH)) ?
                         CW'(DATA_WIDTH) : {1'b0, i_b[SHAMT_WIDTH-1:0]};

    assign add_sum = {1'b0, i_a} + {1'b0, i_b};
    assign sub_sum = {1'b0, i_a} + {1'b0, ~i_b} + (DATA_WIDTH+1)'(1);
    assign add_v   = (i_a[MSB] == i_b[MSB]) && (add_sum[MSB] != i_a[MSB]);
    assign sub_v   = (i_a[MSB] != i_b[MSB]) && (sub_sum[MSB] != i_a[MSB]);

    always_comb begin
        sh_val = result_q;
        sh_out = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_val = {result_q[MSB-1:0], 1'b0};
                sh_out = result_q[MSB];
            end
            OP_SRL: begin
                sh_val = {1'b0, result_q[MSB:1]};
                sh_out = result_q[0];
            end
            OP_SRA: begin
                sh_val = {result_q[MSB], result_q[MSB:1]};
                sh_out = result_q[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Low half of prod_q starts as the multiplier and drains out as the product fills in.
    assign mul_sum   = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                       (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_nz = |mul_sum[DATA_WIDTH:1];
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        prod_d   = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = i_op;
                    err_d   = 1'b0;
                    state_d = DONE;
                    case (i_op)
                        OP_ADD: begin
                            result_d = add_sum[MSB:0];
                            flags_d  = {nz(add_sum[MSB:0]), add_sum[DATA_WIDTH], add_v};
                        end
                        OP_SUB: begin
                            result_d = sub_sum[MSB:0];
                            flags_d  = {nz(sub_sum[MSB:0]), sub_sum[DATA_WIDTH], sub_v};
                        end
                        OP_AND: begin
                            result_d = i_a & i_b;
                            flags_d  = {nz(i_a & i_b), 2'b00};
                        end
                        OP_OR: begin
                            result_d = i_a | i_b;
                            flags_d  = {nz(i_a | i_b), 2'b00};
                        end
                        OP_XOR: begin
                            result_d = i_a ^ i_b;
                            flags_d  = {nz(i_a ^ i_b), 2'b00};
                        end
                        OP_SLT: begin
                            result_d = ($signed(i_a) < $signed(i_b)) ? DATA_WIDTH'(1) : '0;
                            flags_d  = {nz(result_d), 2'b00};
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            result_d = i_a;
                            count_d  = shift_count;
                            flags_d  = {nz(i_a), 2'b00};
                            if (shift_count != '0) begin
                                state_d = SHIFT;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            mcand_d = i_a;
                            prod_d  = {{DATA_WIDTH{1'b0}}, i_b};
                            count_d = CW'(DATA_WIDTH);
                            state_d = MUL;
                        end
`endif
                        default: begin
                            result_d = '0;
                            flags_d  = 4'b0100;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                result_d = sh_val;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    flags_d = {nz(sh_val), sh_out, 1'b0};
                    state_d = DONE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                prod_d  = {mul_sum, prod_q[DATA_WIDTH-1:1]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    result_d = prod_d[MSB:0];
                    flags_d  = {nz(prod_d[MSB:0]), mul_hi_nz, mul_hi_nz};
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= '0;
            prod_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

    localparam int DW = 36;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          ready_out;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    op;
    logic          valid_out;
    logic          cons_ready;
    logic [DW-1:0] result;
    logic [3:0]    flags;
    logic          err;

    int checks = 0;
    int errors = 0;
    int lat;
    int saw_valid;

    alu_seq #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (ready_out),
        .i_a      (a),
        .i_b      (b),
        .i_op     (op),
        .o_valid  (valid_out),
        .i_ready  (cons_ready),
        .o_result (result),
        .o_flags  (flags),
        .o_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the unit idle; returns edges from accept to o_valid.
    task automatic run_op(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                          input logic [3:0] vop, output int latency);
        in_valid = 1'b1;
        a  = va;
        b  = vb;
        op = vop;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        latency = 1;
        while (!valid_out && latency < 100) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic op_check(input string tag, input logic [DW-1:0] va, input logic [DW-1:0] vb,
                            input logic [3:0] vop, input int exp_lat,
                            input logic [DW-1:0] exp_res, input logic [3:0] exp_flags,
                            input logic exp_err);
        int l;
        check({tag, "_ready"}, 64'(ready_out), 64'd1);
        run_op(va, vb, vop, l);
        check({tag, "_lat"}, 64'(l), 64'(exp_lat));
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_flags"}, 64'(flags), 64'(exp_flags));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        cons_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready_out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(ready_out), 64'd1);
        @(negedge clk);

        op_check("add_ovf", 36'h7_FFFF_FFFF, 36'd1, 4'd0, 1, 36'h8_0000_0000, 4'b1001, 1'b0);
        op_check("add_carry", 36'hF_FFFF_FFFF, 36'd1, 4'd0, 1, 36'h0, 4'b0110, 1'b0);
        op_check("sub_eq", 36'd5, 36'd5, 4'd1, 1, 36'h0, 4'b0110, 1'b0);
        op_check("slt_neg", 36'hF_FFFF_FFFF, 36'd1, 4'd5, 1, 36'd1, 4'b0000, 1'b0);
        op_check("xor", 36'hF0F, 36'h0FF, 4'd4, 1, 36'hFF0, 4'b0000, 1'b0);
        op_check("sra4", 36'h8_0000_0000, 36'd4, 4'd8, 5, 36'hF_8000_0000, 4'b1000, 1'b0);
        op_check("sll_sat", 36'd1, 36'd63, 4'd6, 37, 36'h0, 4'b0110, 1'b0);
        op_check("sra_sat", 36'h8_0000_0000, 36'd40, 4'd8, 37, 36'hF_FFFF_FFFF, 4'b1010, 1'b0);
        op_check("srl_zero", 36'hF, 36'd0, 4'd7, 1, 36'hF, 4'b0000, 1'b0);
        op_check("illegal_f", 36'd123, 36'd7, 4'hF, 1, 36'h0, 4'b0100, 1'b1);
        op_check("or_after_err", 36'hF0, 36'h0F, 4'd3, 1, 36'hFF, 4'b0000, 1'b0);
`ifdef ALU_SEQ_MUL_EN
        op_check("mul", 36'd6, 36'd7, 4'd9, 37, 36'd42, 4'b0000, 1'b0);
`else
        op_check("op9_illegal", 36'd6, 36'd7, 4'd9, 1, 36'h0, 4'b0100, 1'b1);
`endif

        // Back-pressure: result held, new request refused while the consumer stalls.
        cons_ready = 1'b0;
        run_op(36'd3, 36'd4, 4'd0, lat);
        check("bp_lat", 64'(lat), 64'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a  = 36'd9;
            b  = 36'd0;
            op = 4'd0;
            check("bp_valid", 64'(valid_out), 64'd1);
            check("bp_result", 64'(result), 64'd7);
            check("bp_flags", 64'(flags), 64'd0);
            check("bp_ready", 64'(ready_out), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        cons_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(valid_out), 64'd0);
        check("bp_release_ready", 64'(ready_out), 64'd1);
        check("bp_release_result", 64'(result), 64'd7);
        op_check("bp_next", 36'd9, 36'd0, 4'd0, 1, 36'd9, 4'b0000, 1'b0);

        // Reset after two of ten shift steps.
        in_valid = 1'b1;
        a  = 36'd1;
        b  = 36'd10;
        op = 4'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 64'(valid_out), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_flags", 64'(flags), 64'd0);
        check("midrst_ready_held", 64'(ready_out), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_out), 64'd1);
        @(negedge clk);
        saw_valid = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid_out) saw_valid++;
            @(negedge clk);
        end
        check("midrst_no_stale", 64'(saw_valid), 64'd0);
        op_check("after_rst_add", 36'd1, 36'd1, 4'd0, 1, 36'd2, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Second-generation ALU with a registered output and a valid/ready handshake on both input and output.
- Adds XOR, signed set-less-than, and iterative shifts to the ADD/SUB/AND/OR set.
- Produces NZCV flags and an illegal-opcode error.
- Sits between the operand-fetch stage and writeback. Back-pressure from writeback stalls the unit.

Parameters:
- DATA_WIDTH, 36, operand and result width in bits (minimum 8).
- ALU_OP_WIDTH, 4, opcode width.
- SHAMT_WIDTH, $clog2(DATA_WIDTH) (localparam, derived), width of the shift-amount field taken from i_b.

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operands and opcode presented.
- o_ready  output  1  unit can accept; equals (state==IDLE) and not i_rst.
- i_a  input  DATA_WIDTH  operand A.
- i_b  input  DATA_WIDTH  operand B; the shift amount is i_b[SHAMT_WIDTH-1:0].
- i_op  input  ALU_OP_WIDTH  opcode.
- o_valid  output  1  result and flags are valid.
- i_ready  input  1  consumer accepts the result.
- o_result  output  DATA_WIDTH  registered result.
- o_flags  output  4  {N,Z,C,V}, registered.
- o_err  output  1  illegal opcode for the current result.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed; result is 1 or 0), 6 SLL, 7 SRL, 8 SRA, 9 MUL (optional). All others are illegal.
- Accept occurs when i_valid and o_ready are both high. On accept, i_a, i_b and i_op are latched. Input changes after accept are ignored.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE, on accept of a single-cycle op (0-5) or an illegal op: go to DONE. Latency is 1 cycle (o_valid rises on the edge after accept).
  - IDLE, on accept of a shift: count = min(shamt, DATA_WIDTH).
    - count 0: go to DONE with result = A and C = 0.
    - count >0: go to SHIFT and shift one bit per cycle until count reaches 0, then go to DONE. Latency is 1 + count cycles.
  - MUL: see Optional Feature.
  - DONE: o_valid = 1. o_result, o_flags and o_err are held stable until i_ready = 1, then go to IDLE. Accept is not possible in the same cycle, so peak throughput is one op per 2 cycles.
- Flags:
  - N = result MSB; Z = (result == 0).
  - ADD: C = carry out of A+B. V = signed overflow.
  - SUB: computed as A+~B+1. C = carry out (1 means A>=B unsigned). V = signed overflow.
  - Shifts: C = last bit shifted out (0 when count is 0). V = 0.
  - AND, OR, XOR, SLT: C = V = 0.
- Illegal opcode: o_result = 0, o_flags = 0100 (Z set), o_err = 1, latency 1.
- Shift amounts >= DATA_WIDTH saturate:
  - SLL and SRL give 0.
  - SRA gives all sign bits.
  - C = last bit shifted out after DATA_WIDTH shifts.
- All arithmetic is modulo 2^DATA_WIDTH. No result is ever wider than DATA_WIDTH.
- Reset (any state, including mid-SHIFT/MUL): on the next edge, state = IDLE, o_valid = 0, o_result = 0, o_flags = 0, o_err = 0, internal counters = 0. The in-flight op is discarded with no output. o_ready is 0 while i_rst is high and 1 on the first cycle after.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - Opcode 9 is legal and runs an unsigned shift-add multiply, one partial product per cycle (IDLE -> MUL for DATA_WIDTH cycles -> DONE). Latency is DATA_WIDTH+1.
  - o_result = low DATA_WIDTH bits of the product.
  - C = V = 1 if the high half of the product is non-zero, else 0.
  - N and Z are computed from o_result.
- Undefined: opcode 9 is illegal (o_err = 1). No MUL state or product register is synthesised.

Test Plan (DATA_WIDTH=36):
- ADD with A=0x7_FFFF_FFFF, B=1, i_ready=1 -> o_valid 1 cycle after accept; result 0x8_0000_0000; flags N=1, Z=0, C=0, V=1; o_err=0.
- SUB with A=5, B=5, then SLT with A=0xF_FFFF_FFFF (-1), B=1 -> SUB gives 0 with Z=1, C=1, V=0; SLT gives 1.
- SRA with A=0x8_0000_0000, B=4 -> o_valid 5 cycles after accept; result 0xF_8000_0000; C=0. Then SLL with A=1, B=63 -> result 0, latency 37 cycles.
- Back-pressure: ADD 3+4 with i_ready=0 for 3 cycles -> o_valid, result 7 and flags held; o_ready=0; a concurrent i_valid with A=9 is not accepted. After i_ready=1, the unit returns to IDLE and the next op is accepted.
- Reset in SHIFT after 2 of 10 shift cycles -> next cycle o_valid=0, result=0, flags=0, o_ready=1; no stale result ever appears.
- Opcode 0xF -> o_err=1, result 0, flags 0100. With ALU_SEQ_MUL_EN defined, MUL 6*7 -> result 42, C=V=0, o_valid 37 cycles after accept.
